// File: rtl/smp_pkg.sv
// smp_pkg: shared widths, FSM state type and address-wrap helper for smp_mem_ctrl.
//   ADDR_W      block/word address width
//   DATA_W      data word width
//   mem_state_t controller FSM states
//   wrap_addr   folds an address into the memory depth
package smp_pkg;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, RESP} mem_state_t;

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a, input int words);
        return ADDR_W'(32'(a) % 32'(words));
    endfunction
endpackage

// File: rtl/smp_mem_ctrl_if.sv
// smp_mem_ctrl_if: request/response bus between the CPU side and smp_mem_ctrl.
//   req_valid/req_ready  request handshake
//   req_we/req_src       writeback (1) or fill (0), requesting CPU
//   req_addr/req_wdata   word address and writeback data
//   rsp_valid            one-cycle fill pulse, no back-pressure
//   rsp_src/rsp_addr/rsp_rdata  fill owner, address and data
//   busy                 controller working or writebacks pending
interface smp_mem_ctrl_if;
    import smp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_src;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_src;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_src, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_src, rsp_addr, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_src, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_src, rsp_addr, rsp_rdata, busy
    );
endinterface

// File: rtl/smp_wb_buf.sv
// smp_wb_buf: 2-entry FIFO writeback buffer with address lookup.
//   clk, rst_n            clock, synchronous active-low reset (drops all entries)
//   addr                  lookup address, also the address of a push
//   push, wdata           coalesce into a matching entry, otherwise append at tail
//   pop                   discard the head entry
//   hit, hit_data         addr matches a valid entry, and that entry's data
//   full, empty           occupancy flags
//   head_addr, head_data  oldest entry, next to be written to memory
module smp_wb_buf import smp_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);
    logic [ADDR_W-1:0] a [2];
    logic [DATA_W-1:0] d [2];
    logic [1:0]        cnt;
    logic [1:0]        m;

    // coalescing keeps addresses unique, so at most one bit of m is set
    assign m         = {cnt == 2'd2 && a[1] == addr, cnt != 2'd0 && a[0] == addr};
    assign hit       = |m;
    assign hit_data  = m[0] ? d[0] : d[1];
    assign full      = cnt == 2'd2;
    assign empty     = cnt == 2'd0;
    assign head_addr = a[0];
    assign head_data = d[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 2'd0;
        end else if (pop) begin
            a[0] <= a[1];
            d[0] <= d[1];
            cnt  <= cnt - 2'd1;
        end else if (push) begin
            if (m[0])
                d[0] <= wdata;
            else if (m[1])
                d[1] <= wdata;
            else if (!full) begin
                a[cnt[0]] <= addr;
                d[cnt[0]] <= wdata;
                cnt       <= cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/smp_mem_ctrl.sv
// smp_mem_ctrl: shared main-memory controller for two CPUs with a 2-entry writeback buffer.
//   clk, rst_n  clock, synchronous active-low reset (memory contents survive reset)
//   bus         smp_mem_ctrl_if.slave: request handshake, fill response, busy
// Writebacks land in the buffer and are drained to memory when the bus is idle
// (or forced when the buffer is full); fills hitting the buffer are forwarded.
module smp_mem_ctrl import smp_pkg::*; #(
    parameter int MEM_LAT   = 4,
    parameter int MEM_WORDS = 2048
) (
    input  logic          clk,
    input  logic          rst_n,
    smp_mem_ctrl_if.slave bus
);
    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    mem_state_t        state;
    logic [3:0]        cnt;
    logic              fwd;
    logic [ADDR_W-1:0] word;
    logic [ADDR_W-1:0] rd_word;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] head_data;
    logic              hit;
    logic              full;
    logic              empty;
    logic              xfer;
    logic              commit;
    logic              rsp_valid;
    logic              rsp_src;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_rdata;
    logic [DATA_W-1:0] mem [MEM_WORDS];

    // the buffer and memory work on wrapped word indices so aliases coalesce
    assign word          = wrap_addr(bus.req_addr, MEM_WORDS);
    assign bus.req_ready = state == IDLE && !full;
    assign xfer          = bus.req_valid && bus.req_ready;
    assign commit        = state == DRAIN && cnt == 4'd0;
    assign bus.busy      = state != IDLE || !empty;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_src   = rsp_src;
    assign bus.rsp_addr  = rsp_addr;
    assign bus.rsp_rdata = rsp_rdata;

    smp_wb_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (word),
        .push      (xfer && bus.req_we),
        .wdata     (bus.req_wdata),
        .pop       (commit),
        .hit       (hit),
        .hit_data  (hit_data),
        .full      (full),
        .empty     (empty),
        .head_addr (head_addr),
        .head_data (head_data)
    );

    always_ff @(posedge clk)
        if (rst_n && commit)
            mem[IDX_W'(head_addr)] <= head_data;

    // A buffer hit takes one READ cycle with the data already latched (fwd),
    // giving a 2-cycle request-to-response latency versus MEM_LAT+1 for a miss.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            fwd       <= 1'b0;
            rd_word   <= '0;
            rsp_valid <= 1'b0;
            rsp_src   <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer && !bus.req_we) begin
                        rsp_src  <= bus.req_src;
                        rsp_addr <= bus.req_addr;
                        rd_word  <= word;
                        fwd      <= hit;
                        cnt      <= hit ? 4'd0 : CNT_LOAD;
                        state    <= READ;
                        if (hit)
                            rsp_rdata <= hit_data;
                    end else if (!xfer && !empty) begin
                        cnt   <= CNT_LOAD;
                        state <= DRAIN;
                    end
                end
                READ: begin
                    if (cnt == 4'd0) begin
                        if (!fwd)
                            rsp_rdata <= mem[IDX_W'(rd_word)];
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else
                        cnt <= cnt - 4'd1;
                end
                DRAIN: begin
                    if (cnt == 4'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_smp_mem_ctrl.sv
// tb_smp_mem_ctrl: self-checking bench for smp_mem_ctrl (vector table, corner sequences, random ops).
module tb_smp_mem_ctrl;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    smp_mem_ctrl_if bus ();

    smp_mem_ctrl #(.MEM_LAT(LAT), .MEM_WORDS(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic        src;
        logic [10:0] addr;
        logic [15:0] data;
        bit          settle;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic src, input logic [10:0] addr, input logic [15:0] data);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_src   = src;
        bus.req_addr  = addr;
        bus.req_wdata = data;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        chk($sformatf("ready_wait_%03h", addr), int'(n < 100), 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_wait", int'(n < 200), 1);
    endtask

    // lat 0 accepts either the forwarding or the memory latency
    task automatic do_read(input logic src, input logic [10:0] addr, input int lat,
                           input logic [15:0] exp, input string tag);
        int n = 1;
        send(1'b0, src, addr, 16'h0);
        while (!bus.rsp_valid && n < 64) begin
            tick();
            n++;
        end
        if (lat == 0)
            chk({tag, "_lat"}, int'(n == 2 || n == LAT + 1), 1);
        else
            chk({tag, "_lat"}, n, lat);
        chk({tag, "_src"}, bus.rsp_src, src);
        chk({tag, "_addr"}, bus.rsp_addr, addr);
        chk({tag, "_data"}, bus.rsp_rdata, exp);
        tick();
        chk({tag, "_pulse"}, bus.rsp_valid, 0);
    endtask

    vec_t        tbl [13];
    bit          written [8];
    logic [15:0] ref_data [8];

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_src   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        tbl[0]  = '{1'b1, 1'b0, 11'h010, 16'hBEEF, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 11'h010, 16'hBEEF, 1'b0, 2};
        tbl[2]  = '{1'b1, 1'b1, 11'h7FF, 16'hA5A5, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b0, 11'h7FF, 16'hA5A5, 1'b1, LAT + 1};
        tbl[4]  = '{1'b0, 1'b1, 11'h010, 16'hBEEF, 1'b0, LAT + 1};
        tbl[5]  = '{1'b1, 1'b0, 11'h030, 16'h1111, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b1, 11'h030, 16'h2222, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0, 11'h030, 16'h2222, 1'b0, 2};
        tbl[8]  = '{1'b0, 1'b1, 11'h030, 16'h2222, 1'b1, LAT + 1};
        tbl[9]  = '{1'b1, 1'b0, 11'h000, 16'h5A5A, 1'b0, 0};
        tbl[10] = '{1'b1, 1'b0, 11'h001, 16'h0F0F, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 11'h001, 16'h0F0F, 1'b0, 2};
        tbl[12] = '{1'b0, 1'b0, 11'h000, 16'h5A5A, 1'b1, LAT + 1};

        repeat (2) tick();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_src", bus.rsp_src, 0);
        chk("rst_rsp_addr", bus.rsp_addr, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", bus.req_ready, 1);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].settle)
                wait_idle(n);
            if (tbl[i].we)
                send(1'b1, tbl[i].src, tbl[i].addr, tbl[i].data);
            else
                do_read(tbl[i].src, tbl[i].addr, tbl[i].lat, tbl[i].data, $sformatf("vec%0d", i));
        end

        // full buffer forces a drain of the oldest entry
        wait_idle(n);
        send(1'b1, 1'b0, 11'h040, 16'hC0DE);
        send(1'b1, 1'b0, 11'h041, 16'hD00D);
        chk("full_ready_low", bus.req_ready, 0);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("full_ready_cycles", n, LAT + 1);
        chk("full_one_left", bus.busy, 1);
        wait_idle(n);
        chk("full_second_drain", n, LAT + 1);
        do_read(1'b0, 11'h040, LAT + 1, 16'hC0DE, "full40");
        do_read(1'b1, 11'h041, LAT + 1, 16'hD00D, "full41");

        // coalesced writebacks need a single drain
        send(1'b1, 1'b0, 11'h050, 16'h1111);
        send(1'b1, 1'b1, 11'h050, 16'h2222);
        chk("coal_ready", bus.req_ready, 1);
        wait_idle(n);
        chk("coal_drain_cycles", n, LAT + 1);
        do_read(1'b0, 11'h050, LAT + 1, 16'h2222, "coal");

        // reset during a read miss
        send(1'b1, 1'b0, 11'h060, 16'h7777);
        wait_idle(n);
        send(1'b0, 1'b1, 11'h060, 16'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rr_rsp_valid", bus.rsp_valid, 0);
        chk("rr_rsp_src", bus.rsp_src, 0);
        chk("rr_rsp_addr", bus.rsp_addr, 0);
        chk("rr_rsp_rdata", bus.rsp_rdata, 0);
        chk("rr_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();
        chk("rr_ready", bus.req_ready, 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            n += int'(bus.rsp_valid);
            tick();
        end
        chk("rr_no_rsp", n, 0);

        // reset during a drain drops the pending writeback
        send(1'b1, 1'b0, 11'h061, 16'hAAAA);
        wait_idle(n);
        send(1'b1, 1'b0, 11'h061, 16'h5555);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rd_busy", bus.busy, 0);
        do_read(1'b0, 11'h061, LAT + 1, 16'hAAAA, "rst_drain");

        // fill miss straight after reset; memory survived the resets
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(1'b1, 11'h010, LAT + 1, 16'hBEEF, "miss");

        // random traffic against a latest-value-per-address model
        for (int i = 0; i < 200; i++) begin
            int          k;
            logic        s;
            logic [15:0] d;
            k = int'($urandom_range(0, 7));
            s = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 5) == 0)
                wait_idle(n);
            if (!written[k] || $urandom_range(0, 1) == 1) begin
                d = 16'($urandom);
                send(1'b1, s, 11'h100 + 11'(k), d);
                ref_data[k] = d;
                written[k]  = 1'b1;
            end else
                do_read(s, 11'h100 + 11'(k), 0, ref_data[k], $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/smp_mem_ctrl.md
SMP_MEM_CTRL -- requirements
Module: smp_mem_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
 - MEM_LAT, 4, main-memory access latency in cycles (legal 1..15)
 - MEM_WORDS, 2048, memory depth in 16-bit words (one word per cache block)
REQ-002 Ports, one per line (name direction width meaning):
 - clk  input  1  single system clock; all state changes on rising edge
 - rst_n  input  1  reset; synchronous, active-low
 - req_valid  input  1  bus presents a memory request
 - req_ready  output  1  controller accepts request this cycle
 - req_we  input  1  1 = writeback of dirty block, 0 = block fill (read)
 - req_src  input  1  requesting CPU id (0/1)
 - req_addr  input  11  block/word address
 - req_wdata  input  16  writeback data
 - rsp_valid  output  1  fill data valid, one-cycle pulse, no back-pressure
 - rsp_src  output  1  CPU id the fill belongs to
 - rsp_addr  output  11  address of returned fill
 - rsp_rdata  output  16  fill data
 - busy  output  1  state != IDLE or writeback buffer non-empty

Function
REQ-003 Handshake: transfer occurs on a cycle where req_valid && req_ready; req_ready = (state==IDLE) && !wb_full; req_ready has no combinational dependence on req_we.
REQ-004 FSM states: IDLE, READ, DRAIN, RESP.
REQ-005 IDLE, accepted writeback: if req_addr matches a buffered entry, overwrite that entry's data (coalesce, count unchanged); else append at tail; remain IDLE.
REQ-006 IDLE, accepted read hitting a buffered entry: forward buffered data, go RESP next cycle (2-cycle request-to-rsp_valid latency).
REQ-007 IDLE, accepted read missing buffer: latch src/addr, load counter MEM_LAT-1, go READ.
REQ-008 IDLE, no transfer, buffer non-empty: go DRAIN with counter MEM_LAT-1; accepted requests take priority over drain unless buffer full (req_ready low forces drain).
REQ-009 READ: decrement counter; at counter 0 capture mem[addr] into rsp_rdata, go RESP; request-to-rsp_valid latency = MEM_LAT+1 cycles.
REQ-010 DRAIN: decrement counter; at counter 0 write head entry to memory, pop head, go IDLE.
REQ-011 RESP: rsp_valid=1 for exactly one cycle with latched rsp_src/rsp_addr/rsp_rdata, then IDLE.
REQ-012 Buffer: 2 entries, FIFO order, at most one entry per address (guaranteed by coalescing); full when count==2.
REQ-013 Address arithmetic: req_addr used unmodified as word index; addresses >= MEM_WORDS wrap modulo MEM_WORDS.
REQ-014 Read-after-writeback to same address always returns the writeback data, whether buffered or drained.

Reset
REQ-015 While rst_n==0 at a clock edge: state=IDLE, counter=0, buffer count=0 (pending writebacks discarded), rsp_valid=0, rsp_src=0, rsp_addr=0, rsp_rdata=0, busy=0; req_ready=1 on first cycle after release.
REQ-016 Reset mid-READ/DRAIN aborts operation with no rsp_valid and no memory write; memory array contents are not cleared.

Structure
REQ-017 Shared package smp_pkg holds ADDR_W=11, DATA_W=16, and typedef enum mem_state_t {IDLE, READ, DRAIN, RESP}.
REQ-018 One sub-module, smp_wb_buf: 2-entry writeback FIFO with address-match lookup (hit, hit_data) and push/coalesce/pop ports.

Verification
REQ-019 Read miss: after reset, read addr 0x010 src 1, mem[0x010]=0xBEEF -> rsp_valid exactly 5 cycles after transfer, rsp_src=1, rsp_rdata=0xBEEF.
REQ-020 Forwarding: writeback 0x020=0x1234 then immediately read 0x020 -> rsp_rdata=0x1234 two cycles after read transfer, no DRAIN in between.
REQ-021 Coalesce: writebacks 0x030=0x1111 then 0x030=0x2222 -> buffer count stays 1; after drain mem[0x030]=0x2222.
REQ-022 Full buffer: writebacks to 0x040 and 0x041 back-to-back -> req_ready=0 next cycle, DRAIN of 0x040 runs 4 cycles, req_ready returns 1 with count 1.
REQ-023 Wrap: read 0x7FF after writeback 0x7FF=0xA5A5 drained -> rsp_rdata=0xA5A5.
REQ-024 Reset mid-READ at cycle 2 -> no rsp_valid; all outputs 0; req_ready=1 the cycle after rst_n deasserts.
